// File: rtl/datamemory_be.sv
// rtl/datamemory_be.sv - byte-enabled RV32I/RV64I data memory with registered loads and fault flags
module datamemory_be #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid,
    output logic                  misaligned,
    output logic                  illegal
);

    localparam int NBYTES = DATA_W / 8;
    localparam int LANE_W = $clog2(NBYTES);
    localparam int WORDS  = (1 << DM_ADDRESS) / NBYTES;
    localparam int IDX_W  = DM_ADDRESS - LANE_W;

    // Word array; contents are deliberately not reset
    logic [DATA_W-1:0] mem [WORDS];

    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] off;
    logic [1:0]        size;
    logic              req_illegal;
    logic              req_misaligned;
    logic              load_ok;
    logic              store_ok;
    logic [NBYTES-1:0] lane_en;
    logic [DATA_W-1:0] wd_shifted;
    int                nb;

    // Captured load state; rd is derived from these so it holds between loads
    logic [DATA_W-1:0] ld_word;
    logic [LANE_W-1:0] ld_off;
    logic [1:0]        ld_size;
    logic              ld_uns;

    logic [DATA_W-1:0] shifted;
    logic              sbit;
    int                nbits;

    assign idx  = a[DM_ADDRESS-1:LANE_W];
    assign off  = a[LANE_W-1:0];
    assign size = Funct3[1:0];

    // Classify the request: illegal encodings first, then natural alignment
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        if (MemRead || MemWrite) begin
            req_illegal = (MemRead && MemWrite)
                       || (Funct3 == 3'b111)
                       || (MemWrite && Funct3[2])
                       || ((DATA_W == 32) && ((size == 2'b11) || (Funct3 == 3'b110)));
            case (size)
                2'b00:   req_misaligned = 1'b0;
                2'b01:   req_misaligned = a[0];
                2'b10:   req_misaligned = |a[1:0];
                default: req_misaligned = |a[2:0];
            endcase
        end
        load_ok  = MemRead && !req_illegal && !req_misaligned;
        store_ok = MemWrite && !req_illegal && !req_misaligned;
    end

    // Store lanes: access-size mask moved up to the lane offset, data aligned with it
    always_comb begin
        lane_en    = '0;
        nb         = 1 << size;
        wd_shifted = wd << {off, 3'b000};
        for (int k = 0; k < NBYTES; k++) begin
            lane_en[k] = (k >= int'(off)) && (k < int'(off) + nb);
        end
    end

    // Byte-lane writes into the addressed word
    always_ff @(posedge clk) begin
        if (store_ok) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (lane_en[k]) begin
                    mem[idx][8*k +: 8] <= wd_shifted[8*k +: 8];
                end
            end
        end
    end

    // Capture legal loads and raise one-cycle status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_word    <= '0;
            ld_off     <= '0;
            ld_size    <= 2'b00;
            ld_uns     <= 1'b0;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            rd_valid   <= load_ok;
            misaligned <= req_misaligned && !req_illegal;
            illegal    <= req_illegal;
            if (load_ok) begin
                ld_word <= mem[idx];
                ld_off  <= off;
                ld_size <= size;
                ld_uns  <= Funct3[2];
            end
        end
    end

    // Extract the accessed field and sign- or zero-extend it to DATA_W
    always_comb begin
        shifted = ld_word >> {ld_off, 3'b000};
        nbits   = 8 << ld_size;
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        case (ld_size)
            2'b00:   sbit = shifted[7];
            2'b01:   sbit = shifted[15];
            2'b10:   sbit = shifted[31];
            default: sbit = shifted[DATA_W-1];
        endcase
        sbit = sbit & ~ld_uns;
        rd   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rd[i] = (i < nbits) ? shifted[i] : sbit;
        end
    end

endmodule

// File: tb/tb_datamemory_be.sv
// tb/tb_datamemory_be.sv - checks datamemory_be at DATA_W=32 and DATA_W=64 against a byte-array model
module tb_datamemory_be;

    logic clk;
    logic reset;

    // Index 0 drives the 32-bit instance, index 1 the 64-bit instance
    logic        mr [2];
    logic        mw [2];
    logic [8:0]  addr [2];
    logic [63:0] wd_in [2];
    logic [2:0]  f3 [2];

    logic [31:0] rd32;
    logic [63:0] rd64;
    logic        rv32, rv64, mis32, mis64, ill32, ill64;

    logic [7:0]  mem_m [2][512];
    logic [63:0] exp_rd [2];
    logic        exp_v [2];
    logic        exp_mis [2];
    logic        exp_ill [2];

    int n_checks;
    int n_pass;
    logic chk_en;

    datamemory_be #(.DM_ADDRESS(9), .DATA_W(32)) u32 (
        .clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]), .a(addr[0]),
        .wd(wd_in[0][31:0]), .Funct3(f3[0]), .rd(rd32), .rd_valid(rv32),
        .misaligned(mis32), .illegal(ill32)
    );

    datamemory_be #(.DM_ADDRESS(9), .DATA_W(64)) u64 (
        .clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]), .a(addr[1]),
        .wd(wd_in[1]), .Funct3(f3[1]), .rd(rd64), .rd_valid(rv64),
        .misaligned(mis64), .illegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Memory as a flat byte array; loads assemble bytes little-endian and extend arithmetically
    task automatic model_step(input int s);
        int          dw, sz, ai;
        logic [63:0] v;
        logic        ill, mis;
        logic [2:0]  f;
        dw = (s == 0) ? 32 : 64;
        f  = f3[s];
        ai = int'(addr[s]);
        sz = 1 << f[1:0];
        exp_v[s]   <= 1'b0;
        exp_mis[s] <= 1'b0;
        exp_ill[s] <= 1'b0;
        if (mr[s] || mw[s]) begin
            ill = (mr[s] && mw[s]) || (f == 3'b111) || (mw[s] && f[2])
               || (dw == 32 && (f[1:0] == 2'b11 || f == 3'b110));
            mis = (ai % sz) != 0;
            if (ill) exp_ill[s] <= 1'b1;
            else if (mis) exp_mis[s] <= 1'b1;
            else if (mw[s]) begin
                for (int k = 0; k < sz; k++) mem_m[s][ai + k] <= wd_in[s][8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < sz; k++) v[8*k +: 8] = mem_m[s][ai + k];
                if (!f[2] && sz < 8 && v[8*sz-1])
                    for (int b = 8*sz; b < 64; b++) v[b] = 1'b1;
                if (dw == 32) v[63:32] = 32'h0;
                exp_rd[s] <= v;
                exp_v[s]  <= 1'b1;
            end
        end
    endtask

    // Model advances on the same edges as the DUTs and clears on reset
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                exp_rd[s]  <= '0;
                exp_v[s]   <= 1'b0;
                exp_mis[s] <= 1'b0;
                exp_ill[s] <= 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // Every-cycle comparison of both instances against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd32",  {32'h0, rd32}, {32'h0, exp_rd[0][31:0]});
            chk("rv32",  {63'h0, rv32}, {63'h0, exp_v[0]});
            chk("mis32", {63'h0, mis32}, {63'h0, exp_mis[0]});
            chk("ill32", {63'h0, ill32}, {63'h0, exp_ill[0]});
            chk("rd64",  rd64, exp_rd[1]);
            chk("rv64",  {63'h0, rv64}, {63'h0, exp_v[1]});
            chk("mis64", {63'h0, mis64}, {63'h0, exp_mis[1]});
            chk("ill64", {63'h0, ill64}, {63'h0, exp_ill[1]});
        end
    end

    task automatic op(input int s, input logic r, input logic w, input logic [2:0] f,
                      input logic [8:0] ad, input logic [63:0] d);
        mr[s] = r;
        mw[s] = w;
        f3[s] = f;
        addr[s] = ad;
        wd_in[s] = d;
        @(posedge clk);
        #1;
        mr[s] = 1'b0;
        mw[s] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        chk_en   = 1'b0;
        reset    = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mr[s] = 1'b0; mw[s] = 1'b0; addr[s] = '0; wd_in[s] = '0; f3[s] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_rd32", {32'h0, rd32}, 64'h0);
        chk("reset_rv32", {63'h0, rv32}, 64'h0);
        chk("reset_rd64", rd64, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // 32-bit: word store then full and partial loads, back to back
        op(0, 0, 1, 3'b010, 9'h010, 64'h800080F1);
        op(0, 1, 0, 3'b010, 9'h010, 64'h0);
        chk("lw_rd", {32'h0, rd32}, 64'h800080F1);
        chk("lw_valid", {63'h0, rv32}, 64'h1);
        @(negedge clk);
        chk("lw_pulse_drop", {63'h0, rv32}, 64'h0);
        chk("lw_hold", {32'h0, rd32}, 64'h800080F1);
        op(0, 1, 0, 3'b000, 9'h010, 64'h0);
        chk("lb", {32'h0, rd32}, 64'hFFFFFFF1);
        op(0, 1, 0, 3'b100, 9'h011, 64'h0);
        chk("lbu", {32'h0, rd32}, 64'h00000080);
        op(0, 1, 0, 3'b001, 9'h012, 64'h0);
        chk("lh", {32'h0, rd32}, 64'hFFFF8000);
        op(0, 1, 0, 3'b101, 9'h010, 64'h0);
        chk("lhu", {32'h0, rd32}, 64'h000080F1);

        // Partial stores touch only their lanes
        op(0, 0, 1, 3'b000, 9'h013, 64'h123456AB);
        op(0, 1, 0, 3'b010, 9'h010, 64'h0);
        chk("sb_lw", {32'h0, rd32}, 64'hAB0080F1);
        op(0, 0, 1, 3'b001, 9'h010, 64'h0000CDEF);
        op(0, 1, 0, 3'b010, 9'h010, 64'h0);
        chk("sh_lw", {32'h0, rd32}, 64'hAB00CDEF);

        // Misaligned and illegal requests are flagged and have no effect
        op(0, 1, 0, 3'b010, 9'h012, 64'h0);
        chk("lw_mis", {63'h0, mis32}, 64'h1);
        chk("lw_mis_nov", {63'h0, rv32}, 64'h0);
        chk("lw_mis_hold", {32'h0, rd32}, 64'hAB00CDEF);
        op(0, 0, 1, 3'b001, 9'h011, 64'h00001111);
        chk("sh_mis", {63'h0, mis32}, 64'h1);
        op(0, 1, 0, 3'b011, 9'h010, 64'h0);
        chk("ld_on32_ill", {63'h0, ill32}, 64'h1);
        chk("ld_on32_notmis", {63'h0, mis32}, 64'h0);
        op(0, 1, 1, 3'b010, 9'h010, 64'h0);
        chk("rw_ill", {63'h0, ill32}, 64'h1);
        op(0, 0, 1, 3'b101, 9'h011, 64'h0);
        chk("su_ill_prio", {63'h0, ill32}, 64'h1);
        chk("su_ill_nomis", {63'h0, mis32}, 64'h0);
        op(0, 1, 0, 3'b010, 9'h010, 64'h0);
        chk("after_faults", {32'h0, rd32}, 64'hAB00CDEF);

        // 64-bit instance
        op(1, 0, 1, 3'b011, 9'h008, 64'h0123456789ABCDEF);
        op(1, 1, 0, 3'b110, 9'h00C, 64'h0);
        chk("lwu64", rd64, 64'h0000000001234567);
        op(1, 1, 0, 3'b000, 9'h008, 64'h0);
        chk("lb64", rd64, 64'hFFFFFFFFFFFFFFEF);
        op(1, 1, 0, 3'b010, 9'h008, 64'h0);
        chk("lw64", rd64, 64'hFFFFFFFF89ABCDEF);
        op(1, 1, 0, 3'b011, 9'h00C, 64'h0);
        chk("ld_mis64", {63'h0, mis64}, 64'h1);

        // Reset right after an LD is captured cancels its result
        mr[1] = 1'b1; f3[1] = 3'b011; addr[1] = 9'h008;
        @(posedge clk);
        #1;
        mr[1] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rd64", rd64, 64'h0);
        chk("rst_rv64", {63'h0, rv64}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rv64", {63'h0, rv64}, 64'h0);
        op(1, 1, 0, 3'b011, 9'h008, 64'h0);
        chk("ld64", rd64, 64'h0123456789ABCDEF);
        chk("ld64_valid", {63'h0, rv64}, 64'h1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
